// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one imem request at a time and buffers
// {pc, instr} pairs in a small circular FIFO drained by decode; branches flush.
module instr_fetch_queue #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [0:31] cur_pc,
    input  logic [0:31] next_pc,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    input  logic        br_taken,
    input  logic [0:31] br_target,
    output logic        instr_valid,
    output logic [0:31] instr_out,
    output logic [0:31] instr_pc,
    input  logic        instr_ready
);

    localparam int           AW   = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {SETTLE, ISSUE, WAIT, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [0:31]   cur_pc_q, cur_pc_d;
    logic          req_q, req_d;
    logic [0:31]   addr_q, addr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [0:31]   fifo_pc_q   [DEPTH];
    logic [0:31]   fifo_data_q [DEPTH];
    logic          push, pop;

    always_comb begin
        state_d  = state_q;
        cur_pc_d = cur_pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        push     = 1'b0;
        case (state_q)
            SETTLE: state_d = ISSUE;
            ISSUE: begin
                if (count_q < FULL) begin
                    req_d   = 1'b1;
                    addr_d  = cur_pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    push     = 1'b1;
                    cur_pc_d = next_pc;
                    req_d    = 1'b0;
                    state_d  = SETTLE;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
        // Redirect wins over everything; an unacked request must still be drained.
        if (br_taken) begin
            push     = 1'b0;
            cur_pc_d = br_target;
            case (state_q)
                SETTLE, ISSUE: begin
                    req_d   = 1'b0;
                    state_d = SETTLE;
                end
                WAIT:    state_d = imem_ack ? SETTLE : DRAIN;
                default: ;
            endcase
        end
    end

    always_comb begin
        pop      = instr_valid && instr_ready && !br_taken;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (br_taken) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SETTLE;
            cur_pc_q <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_pc_q <= cur_pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= cur_pc_q;
            fifo_data_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign cur_pc      = cur_pc_q;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a latency-configurable memory model, a
// +4 next_pc model and a scoreboard monitor checking every accepted instruction.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] cur_pc, next_pc, imem_addr, imem_rdata, br_target;
    logic [0:31] instr_out, instr_pc;
    logic        imem_req, imem_ack, br_taken, instr_valid, instr_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   ack_cnt = 0;
    int   mem_lat = 0;
    int   wcnt    = 0;

    instr_fetch_queue #(.RESET_PC(32'd200), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .cur_pc(cur_pc), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    assign next_pc = cur_pc + 32'd4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory: acks after mem_lat wait cycles; data = {A5A5, low half of addr}.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end else if (imem_req) begin
                if (wcnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = {16'hA5A5, imem_addr[16:31]};
                    ack_cnt++;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard monitor: one pop per accepted head, void when a branch is present.
    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready && !br_taken) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h, expected no entry", instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_data", instr_out, e.data);
            end
        end
    end

    initial begin
        rst         = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        instr_ready = 1'b0;
        repeat (3) tick();
        chk("rst_cur_pc", cur_pc, 32'd200);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);

        // Reset release and first fetch, with decode stalled
        rst = 1'b1;
        tick();
        chk("first_req_early", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd200);

        // Backpressure: only DEPTH entries fetched, then fetch stalls
        repeat (20) tick();
        chk("bp_acks", ack_cnt, 32'd2);
        chk("bp_req_idle", {31'd0, imem_req}, 32'd0);
        chk("bp_head_pc", instr_pc, 32'd200);
        chk("bp_cur_pc", cur_pc, 32'd208);

        push_exp(32'd200, 32'hA5A5_00C8);
        push_exp(32'd204, 32'hA5A5_00CC);
        mem_lat     = 3;
        instr_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        chk("bp_drained", exp_q.size(), 32'd0);
        instr_ready = 1'b0;

        // Wait states: request for 208 held stable
        for (int k = 0; k < 10 && !imem_req; k++) tick();
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", {31'd0, imem_req}, 32'd1);
            chk("ws_addr", imem_addr, 32'd208);
            tick();
        end
        for (int k = 0; k < 10 && !instr_valid; k++) tick();
        chk("ws_head_pc", instr_pc, 32'd208);
        chk("ws_head_data", instr_out, 32'hA5A5_00D0);
        chk("ws_acks", ack_cnt, 32'd3);

        // Branch while the request for 212 is outstanding
        for (int k = 0; k < 15 && !(imem_req && imem_addr == 32'd212); k++) tick();
        chk("br_pending_addr", imem_addr, 32'd212);
        chk("br_pre_valid", {31'd0, instr_valid}, 32'd1);
        br_taken  = 1'b1;
        br_target = 32'h400;
        tick();
        br_taken = 1'b0;
        chk("br_flush", {31'd0, instr_valid}, 32'd0);
        chk("br_cur_pc", cur_pc, 32'h400);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'd212);
        push_exp(32'h400, 32'hA5A5_0400);
        push_exp(32'h404, 32'hA5A5_0404);
        instr_ready = 1'b1;
        for (int k = 0; k < 10 && imem_req; k++) tick();
        for (int k = 0; k < 10 && !imem_req; k++) tick();
        chk("br_req_target", imem_addr, 32'h400);
        for (int k = 0; k < 10 && imem_req; k++) tick();
        for (int k = 0; k < 10 && !imem_req; k++) tick();
        chk("br_req_next", imem_addr, 32'h404);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("br_drained", exp_q.size(), 32'd0);

        // Branch coincident with ack and pop
        instr_ready = 1'b0;
        mem_lat     = 0;
        for (int k = 0; k < 20 && !instr_valid; k++) tick();
        chk("co_head_pc", instr_pc, 32'h408);
        for (int k = 0; k < 20 && !imem_ack; k++) tick();
        chk("co_ack_addr", imem_addr, 32'h40C);
        instr_ready = 1'b1;
        br_taken    = 1'b1;
        br_target   = 32'h800;
        tick();
        br_taken = 1'b0;
        chk("co_flush", {31'd0, instr_valid}, 32'd0);
        chk("co_cur_pc", cur_pc, 32'h800);
        chk("co_req", {31'd0, imem_req}, 32'd0);
        push_exp(32'h800, 32'hA5A5_0800);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("co_drained", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a WAIT
        instr_ready = 1'b0;
        mem_lat     = 3;
        for (int k = 0; k < 40 && !(instr_valid && imem_req); k++) tick();
        chk("ar_pre_req", {31'd0, imem_req}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_req", {31'd0, imem_req}, 32'd0);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_cur_pc", cur_pc, 32'd200);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("ar_refetch_req", {31'd0, imem_req}, 32'd1);
        chk("ar_refetch_addr", imem_addr, 32'd200);
        chk("final_sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
